// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command decoder.
package uart_cmd_decoder_pkg;

  // Decoder FSM states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StLen   = 3'd2,
    StData  = 3'd3,
    StIssue = 3'd4,
    StNext  = 3'd5
  } state_e;

  // Default command bytes.
  localparam logic [7:0] CmdWriteDef = 8'h57;  // 'W'
  localparam logic [7:0] CmdFillDef  = 8'h46;  // 'F'

  // Index of the final byte of each multi-byte field.
  localparam logic [1:0] AddrLastIdx = 2'd2;
  localparam logic [1:0] LenLastIdx  = 2'd1;
  localparam logic [1:0] DataLastIdx = 2'd1;

  // Shift a received byte into the low end of a 16-bit MSB-first field.
  function automatic logic [15:0] shift_in16(input logic [15:0] cur, input logic [7:0] b);
    return {cur[7:0], b};
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_rx_byte_strobe.sv
// Turns the UART "data available" level into a single-cycle byte strobe plus captured byte.
module uart_cmd_decoder_rx_byte_strobe (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_stb,
  output logic [7:0] o_byte
);

  logic       r_valid;
  logic       r_valid_prev;
  logic       r_stb;
  logic [7:0] r_byte;
  logic       w_rise;

  // One strobe per rising edge, however long the level stays high.
  assign w_rise = r_valid & ~r_valid_prev;

  // Register the level, detect its rise, then capture the byte on the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_valid_prev <= 1'b0;
      r_stb        <= 1'b0;
      r_byte       <= 8'h00;
    end else begin
      r_valid      <= i_valid;
      r_valid_prev <= r_valid;
      r_stb        <= w_rise;
      if (w_rise) begin
        r_byte <= i_data;
      end
    end
  end

  assign o_stb  = r_stb;
  assign o_byte = r_byte;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes 'W' (single write) and 'F' (block fill) host packets into 16-bit memory word writes.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  CMD_WRITE      = CmdWriteDef,
  parameter logic [7:0]  CMD_FILL       = CmdFillDef
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ValidData,
  input  logic [7:0]        ReceivedData,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemData,
  input  logic              MemAck,
  output logic              Busy,
  output logic              CmdDone,
  output logic              ErrUnknown,
  output logic              ErrTimeout,
  output logic              ErrOverrun
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic              w_byte_stb;
  logic [7:0]        w_byte;

  state_e            r_state,   w_state_nxt;
  logic              r_fill,    w_fill_nxt;
  logic [1:0]        r_idx,     w_idx_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [15:0]       r_len,     w_len_nxt;
  logic [15:0]       r_data,    w_data_nxt;
  logic [15:0]       r_rem,     w_rem_nxt;
  logic [TmoW-1:0]   r_tmo,     w_tmo_nxt;
  logic              r_done,    w_done_nxt;
  logic              r_err_unk, w_err_unk_nxt;
  logic              r_err_tmo, w_err_tmo_nxt;
  logic              r_err_ovr, w_err_ovr_nxt;
  logic              w_collect;
  logic              w_tmo_hit;

  uart_cmd_decoder_rx_byte_strobe u_rx_byte_strobe (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_valid(ValidData),
    .i_data (ReceivedData),
    .o_stb  (w_byte_stb),
    .o_byte (w_byte)
  );

  // Only the packet-collecting states run the inter-byte timer.
  assign w_collect = (r_state == StAddr) || (r_state == StLen) || (r_state == StData);
  assign w_tmo_hit = (r_tmo == TmoLast);

  // Next-state, field shifters, write sequencing and pulse generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_idx_nxt     = r_idx;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    w_data_nxt    = r_data;
    w_rem_nxt     = r_rem;
    w_done_nxt    = 1'b0;
    w_err_unk_nxt = 1'b0;
    w_err_tmo_nxt = 1'b0;
    w_err_ovr_nxt = 1'b0;
    // A byte strobe always clears the timer, even when it coincides with expiry.
    w_tmo_nxt     = '0;
    if (w_collect && !w_byte_stb) begin
      w_tmo_nxt = r_tmo + TmoW'(1);
    end

    case (r_state)
      StIdle: begin
        if (w_byte_stb) begin
          if ((w_byte == CMD_WRITE) || (w_byte == CMD_FILL)) begin
            w_fill_nxt  = (w_byte == CMD_FILL);
            w_idx_nxt   = '0;
            w_state_nxt = StAddr;
          end else begin
            w_err_unk_nxt = 1'b1;
          end
        end
      end
      StAddr: begin
        if (w_byte_stb) begin
          // Bits above ADDR_W fall off the top of the shifter.
          w_addr_nxt = ADDR_W'({r_addr, w_byte});
          w_idx_nxt  = r_idx + 2'd1;
          if (r_idx == AddrLastIdx) begin
            w_idx_nxt   = '0;
            w_state_nxt = r_fill ? StLen : StData;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end
      end
      StLen: begin
        if (w_byte_stb) begin
          w_len_nxt = shift_in16(r_len, w_byte);
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == LenLastIdx) begin
            w_idx_nxt   = '0;
            w_state_nxt = StData;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end
      end
      StData: begin
        if (w_byte_stb) begin
          w_data_nxt = shift_in16(r_data, w_byte);
          w_idx_nxt  = r_idx + 2'd1;
          if (r_idx == DataLastIdx) begin
            w_idx_nxt = '0;
            if (r_fill && (r_len == 16'd0)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = StIdle;
            end else begin
              w_rem_nxt   = r_len;
              w_state_nxt = StIssue;
            end
          end
        end else if (w_tmo_hit) begin
          w_err_tmo_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end
      end
      StIssue: begin
        w_err_ovr_nxt = w_byte_stb;
        if (MemAck) begin
          if (r_fill) begin
            w_state_nxt = StNext;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      StNext: begin
        w_err_ovr_nxt = w_byte_stb;
        w_addr_nxt    = r_addr + ADDR_W'(1);
        w_rem_nxt     = r_rem - 16'd1;
        if (r_rem == 16'd1) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StIssue;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet without pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_fill    <= 1'b0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_rem     <= '0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_err_unk <= 1'b0;
      r_err_tmo <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fill    <= w_fill_nxt;
      r_idx     <= w_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_len     <= w_len_nxt;
      r_data    <= w_data_nxt;
      r_rem     <= w_rem_nxt;
      r_tmo     <= w_tmo_nxt;
      r_done    <= w_done_nxt;
      r_err_unk <= w_err_unk_nxt;
      r_err_tmo <= w_err_tmo_nxt;
      r_err_ovr <= w_err_ovr_nxt;
    end
  end

  assign MemReq     = (r_state == StIssue);
  assign MemAddr    = r_addr;
  assign MemData    = r_data;
  assign Busy       = (r_state != StIdle);
  assign CmdDone    = r_done;
  assign ErrUnknown = r_err_unk;
  assign ErrTimeout = r_err_tmo;
  assign ErrOverrun = r_err_ovr;

endmodule
